// File: rtl/snake_pkg.sv
// Shared snake-game constants: screen size, pixel field widths,
// arbiter lock state encoding and a round-robin helper.
package snake_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int GID_W    = 3;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_t;

  function automatic int rr_next(int i, int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of req scanning from ptr upward.
// Ports: req, ptr in; grant (one-hot or zero), idx, found out.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter with burst lock sharing the VGA write port.
// Ports: clk, reset_n, req_valid/x/y/colour/burst in; req_ready
// (comb), plot, x_out, y_out, colour_out, grant_id, locked (reg).
// Optional: PIXEL_CLIP_EN suppresses plot for off-screen writes.
module pixel_write_arbiter
  import snake_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  input  logic [NUM_REQ-1:0]           req_burst,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         plot,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic [COLOUR_W-1:0]          colour_out,
  output logic [GID_W-1:0]             grant_id,
  output logic                         locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t    state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] rr_ptr, rr_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [X_W-1:0]      xs [NUM_REQ];
  logic [Y_W-1:0]      ys [NUM_REQ];
  logic [COLOUR_W-1:0] cs [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign xs[i] = req_x[i*X_W +: X_W];
    assign ys[i] = req_y[i*Y_W +: Y_W];
    assign cs[i] = req_colour[i*COLOUR_W +: COLOUR_W];
  end

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win;
  logic               xfer;
  logic               win_burst;
  logic               clip;

  // While locked only the owner may be picked.
  always_comb begin
    eligible = req_valid;
    if (state == ARB_LOCKED)
      eligible = req_valid & (NUM_REQ'(1) << owner);
  end

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .found (xfer)
  );

  assign req_ready = grant;
  assign win_burst = req_burst[win];
  assign locked    = (state == ARB_LOCKED);

`ifdef PIXEL_CLIP_EN
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);
  assign clip = (xs[win] >= X_LIM) || (ys[win] >= Y_LIM);
`else
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ARB_UNLOCKED;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
      cnt    <= cnt_n;
    end
  end

  // Idle counter stops at LOCK_TIMEOUT-1; the idle cycle that
  // finds it there releases the lock.
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    unique case (state)
      ARB_UNLOCKED: begin
        if (xfer) begin
          rr_n = IW'(rr_next(int'(win), NUM_REQ));
          if (win_burst) begin
            state_n = ARB_LOCKED;
            owner_n = win;
            cnt_n   = '0;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer) begin
          cnt_n = '0;
          if (!win_burst) begin
            state_n = ARB_UNLOCKED;
            rr_n    = IW'(rr_next(int'(owner), NUM_REQ));
          end
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_n = ARB_UNLOCKED;
          rr_n    = IW'(rr_next(int'(owner), NUM_REQ));
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ARB_UNLOCKED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      grant_id   <= '0;
    end else begin
      plot <= xfer && !clip;
      if (xfer) begin
        grant_id <= GID_W'(win);
        if (!clip) begin
          x_out      <= xs[win];
          y_out      <= ys[win];
          colour_out <= cs[win];
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: vector table,
// directed lock/timeout/reset sequences and a random phase.
module tb_pixel_write_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_x;
  logic [N*7-1:0] req_y;
  logic [N*3-1:0] req_colour;
  logic [N-1:0]   req_burst;
  logic [N-1:0]   req_ready;
  logic           plot;
  logic [7:0]     x_out;
  logic [6:0]     y_out;
  logic [2:0]     colour_out;
  logic [2:0]     grant_id;
  logic           locked;

  pixel_write_arbiter #(
    .NUM_REQ      (N),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_burst  (req_burst),
    .req_ready  (req_ready),
    .plot       (plot),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .grant_id   (grant_id),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] bv, bb;
  logic [7:0]   bx [N];
  logic [6:0]   by [N];
  logic [2:0]   bc [N];

  // reference state
  bit         m_lock;
  int         m_owner, m_idle, m_rr;
  logic       m_plot;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  int         m_gid;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_lock = 0; m_owner = 0; m_idle = 0; m_rr = 0;
    m_plot = 0; m_x = 0; m_y = 0; m_c = 0; m_gid = 0;
  endtask

  function automatic int m_pick();
    if (m_lock) return bv[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (bv[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic m_step(int w);
    bit cl;
    cl = 0;
    if (w >= 0) begin
`ifdef PIXEL_CLIP_EN
      cl = (bx[w] >= 160) || (by[w] >= 120);
`endif
      m_plot = !cl;
      m_gid  = w;
      if (!cl) begin
        m_x = bx[w]; m_y = by[w]; m_c = bc[w];
      end
      if (!m_lock) begin
        m_rr = (w + 1) % N;
        if (bb[w]) begin
          m_lock = 1; m_owner = w; m_idle = 0;
        end
      end else if (!bb[w]) begin
        m_lock = 0; m_rr = (m_owner + 1) % N;
      end else begin
        m_idle = 0;
      end
    end else begin
      m_plot = 0;
      if (m_lock) begin
        m_idle++;
        if (m_idle >= TO) begin
          m_lock = 0; m_rr = (m_owner + 1) % N;
        end
      end
    end
  endtask

  task automatic pack();
    req_valid = bv;
    req_burst = bb;
    for (int i = 0; i < N; i++) begin
      req_x[i*8 +: 8]      = bx[i];
      req_y[i*7 +: 7]      = by[i];
      req_colour[i*3 +: 3] = bc[i];
    end
  endtask

  // Called just after a rising edge; returns the sampled ready.
  task automatic cycle(output logic [N-1:0] got);
    int w;
    logic [N-1:0] er;
    pack();
    #4;
    got = req_ready;
    w = m_pick();
    er = (w >= 0) ? N'(1 << w) : '0;
    chk("ready", req_ready, er);
    m_step(w);
    @(posedge clk);
    #1;
    chk("plot", plot, m_plot);
    chk("x_out", x_out, m_x);
    chk("y_out", y_out, m_y);
    chk("colour_out", colour_out, m_c);
    chk("grant_id", grant_id, m_gid);
    chk("locked", locked, m_lock);
  endtask

  typedef struct {
    logic [2:0] v;
    logic [2:0] b;
    logic [2:0] rdy;
    logic       p;
    logic [7:0] xo;
    logic       lk;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [N-1:0] got;
    logic [N-1:0] last;

    tbl[0]  = '{3'b111, 3'b000, 3'b001, 1'b1, 8'd10, 1'b0};
    tbl[1]  = '{3'b111, 3'b000, 3'b010, 1'b1, 8'd20, 1'b0};
    tbl[2]  = '{3'b111, 3'b000, 3'b100, 1'b1, 8'd30, 1'b0};
    tbl[3]  = '{3'b111, 3'b000, 3'b001, 1'b1, 8'd10, 1'b0};
    tbl[4]  = '{3'b111, 3'b000, 3'b010, 1'b1, 8'd20, 1'b0};
    tbl[5]  = '{3'b111, 3'b000, 3'b100, 1'b1, 8'd30, 1'b0};
    tbl[6]  = '{3'b001, 3'b000, 3'b001, 1'b1, 8'd10, 1'b0};
    tbl[7]  = '{3'b111, 3'b010, 3'b010, 1'b1, 8'd20, 1'b1};
    tbl[8]  = '{3'b111, 3'b010, 3'b010, 1'b1, 8'd20, 1'b1};
    tbl[9]  = '{3'b111, 3'b010, 3'b010, 1'b1, 8'd20, 1'b1};
    tbl[10] = '{3'b111, 3'b010, 3'b010, 1'b1, 8'd20, 1'b1};
    tbl[11] = '{3'b111, 3'b000, 3'b010, 1'b1, 8'd20, 1'b0};
    tbl[12] = '{3'b111, 3'b000, 3'b100, 1'b1, 8'd30, 1'b0};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 1'b0, 8'd30, 1'b0};

    bv = '0; bb = '0;
    for (int i = 0; i < N; i++) begin
      bx[i] = 8'(10 * (i + 1));
      by[i] = 7'(i + 1);
      bc[i] = 3'(i + 1);
    end
    pack();
    m_reset();

    // reset state
    #12;
    chk("rst_plot", plot, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_colour", colour_out, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", req_ready, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // round robin and burst lock vectors
    for (int i = 0; i < 14; i++) begin
      bv = tbl[i].v;
      bb = tbl[i].b;
      cycle(got);
      chk($sformatf("tbl%0d_ready", i), got, tbl[i].rdy);
      chk($sformatf("tbl%0d_plot", i), plot, tbl[i].p);
      chk($sformatf("tbl%0d_x", i), x_out, tbl[i].xo);
      chk($sformatf("tbl%0d_lock", i), locked, tbl[i].lk);
    end

    // owner 1 locks, then goes idle until the timeout
    bv = 3'b010; bb = 3'b010;
    cycle(got);
    chk("to_lock_ready", got, 3'b010);
    chk("to_locked", locked, 1);
    bv = 3'b100; bb = 3'b000;
    for (int k = 1; k <= TO; k++) begin
      cycle(got);
      chk($sformatf("to_idle%0d_ready", k), got, 3'b000);
      chk($sformatf("to_idle%0d_lock", k), locked, (k < TO) ? 1 : 0);
    end
    cycle(got);
    chk("to_after_ready", got, 3'b100);
    chk("to_after_gid", grant_id, 2);

    // single requester 2 at the screen corner
    bv = 3'b100; bb = 3'b000;
    bx[2] = 8'd159; by[2] = 7'd119; bc[2] = 3'b101;
    cycle(got);
    chk("corner_ready", got, 3'b100);
    chk("corner_plot", plot, 1);
    chk("corner_x", x_out, 159);
    chk("corner_y", y_out, 119);
    chk("corner_c", colour_out, 5);
    chk("corner_gid", grant_id, 2);

    // off-screen write from requester 0
    bv = 3'b001;
    bx[0] = 8'd200; by[0] = 7'd5;
    cycle(got);
    chk("clip_ready", got, 3'b001);
`ifdef PIXEL_CLIP_EN
    chk("clip_plot", plot, 0);
    chk("clip_x", x_out, 159);
`else
    chk("clip_plot", plot, 1);
    chk("clip_x", x_out, 200);
`endif
    bx[0] = 8'd10; by[0] = 7'd1;

    // reset while requester 1 holds a burst lock
    bv = 3'b010; bb = 3'b010;
    cycle(got);
    bv = 3'b111;
    cycle(got);
    chk("mid_locked_pre", locked, 1);
    chk("mid_plot_pre", plot, 1);
    pack();
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_x", x_out, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_noplot", plot, 0);
    #3;
    reset_n = 1'b1;
    bb = 3'b000;
    cycle(got);
    chk("mid_after_ready", got, 3'b001);
    chk("mid_after_gid", grant_id, 0);

    // random traffic honouring the hold-while-pending rule
    last = '1;
    bv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bv[i] || last[i]) begin
          bv[i] = ($urandom_range(0, 9) < 6);
          bb[i] = ($urandom_range(0, 9) < 3);
          bx[i] = 8'($urandom_range(0, 255));
          by[i] = 7'($urandom_range(0, 127));
          bc[i] = 3'($urandom_range(0, 7));
        end
      end
      cycle(last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Shares the single VGA framebuffer write port (plot/x/y/colour) between several pixel producers: the snake datapath, the splash/black-screen drawer and the food spawner.
- Uses a valid/ready handshake per requester and round-robin arbitration.
- A burst lock lets a full-screen clear or splash finish without being interleaved.
- Replaces ad-hoc priority muxing in the top-level snake interface.
- Output is registered and drives the VGA adapter directly.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- LOCK_TIMEOUT, 16, idle cycles (owner's valid low) after which a burst lock is forcibly released.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  requester i has a pixel write pending
- req_x  input  NUM_REQ*8  packed x coordinates; slice i = bits [8i+7:8i]
- req_y  input  NUM_REQ*7  packed y coordinates
- req_colour  input  NUM_REQ*3  packed 3-bit colours
- req_burst  input  NUM_REQ  requester i wants to keep ownership after this write
- req_ready  output  NUM_REQ  one-hot (or zero) write-accepted strobe, combinational
- plot  output  1  framebuffer write enable, registered
- x_out  output  8  registered x
- y_out  output  7  registered y
- colour_out  output  3  registered colour
- grant_id  output  3  index of the last accepted requester, registered
- locked  output  1  a burst lock is currently held

Behaviour:
- Reset: asynchronous on reset_n low. Clears the following:
  - plot=0, x_out=0, y_out=0, colour_out=0, grant_id=0, locked=0
  - round-robin pointer rr_ptr=0
  - lock owner=0, timeout counter=0
- Reset mid-burst drops the lock immediately; no write is issued in the reset cycle.
- Handshake: a transfer occurs in any cycle where req_valid[i]=1 and req_ready[i]=1. Requesters hold x/y/colour/burst stable while valid=1 and ready=0. The VGA side has no backpressure, so exactly one transfer is possible per cycle whenever any valid requester is eligible.
- Arbitration is combinational within the cycle:
  - LOCKED state: only the owner is eligible. ready[owner]=valid[owner]; all other ready bits are 0.
  - UNLOCKED state: winner = first i with valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
- Latency: 1 cycle. On a transfer in cycle t, at edge t+1:
  - plot=1
  - x_out, y_out, colour_out and grant_id take the winner's values
- If no transfer occurs, plot=0 at the next edge and x/y/colour/grant_id hold their previous values.
- rr_ptr: updates to (winner+1) mod NUM_REQ on every transfer made in UNLOCKED state. Holds while LOCKED.
- Lock FSM (UNLOCKED, LOCKED):
  - UNLOCKED -> LOCKED: transfer with req_burst[winner]=1. Owner = winner; timeout counter cleared.
  - LOCKED -> LOCKED: owner transfers with burst=1. Counter cleared.
  - LOCKED -> UNLOCKED: owner transfers with burst=0. This final write still issues; rr_ptr = owner+1.
  - LOCKED, owner valid=0: counter increments. When counter reaches LOCK_TIMEOUT-1, go to UNLOCKED next edge and set rr_ptr = owner+1.
  - Counter saturates; it never wraps.
- locked output: 1 exactly while in LOCKED state, registered.
- Simultaneous valid from all requesters, unlocked: exactly one ready bit is asserted. Over NUM_REQ consecutive cycles each requester is served once.
- Winner's burst=1 while another requester is valid: the winner keeps ownership. The other requester waits indefinitely, except for timeout.

Optional Feature:
- Macro: PIXEL_CLIP_EN.
- Defined: a transfer with x>=160 or y>=120 is accepted (ready=1, lock/rr_ptr update normally) but plot stays 0 for that write. x/y/colour hold their old values.
- Undefined: every transfer produces plot=1 with coordinates passed unchanged.

Decomposition:
- Shared package snake_pkg:
  - SCREEN_W=160, SCREEN_H=120
  - X_W=8, Y_W=7, COLOUR_W=3
  - lock state encoding (ARB_UNLOCKED=0, ARB_LOCKED=1)
- One sub-module rr_priority_picker: combinational. Inputs are a request vector and a pointer; outputs are a one-hot grant and the winner index. It is instantiated once, and also reused by future audio/sprite arbiters.

Test Plan:
- All three requesters valid continuously, burst=0, distinct x=10/20/30 -> ready order 0,1,2,0,1,2; plot=1 every cycle from cycle 1; x_out sequence 10,20,30,...
- Requester 1 bursts 5 writes (burst=1 on the first 4, 0 on the 5th) while 0 and 2 stay valid -> req_ready[0]/[2] stay 0 for 5 cycles; locked=1 for 4 cycles; next grant goes to 2.
- Owner 1 locks, then drops valid with LOCK_TIMEOUT=16 -> after 16 idle cycles locked=0; requester 2 gets ready on the following cycle.
- reset_n pulsed low while locked mid-burst -> plot/locked/x_out go to 0 immediately; after release the first grant goes to requester 0.
- Single requester 2 valid, x=159, y=119, colour=3'b101 -> ready[2]=1 same cycle; next cycle plot=1, x_out=159, y_out=119, colour_out=5, grant_id=2.
- With PIXEL_CLIP_EN, requester 0 writes x=200, y=5 -> ready[0]=1; plot stays 0. Without the macro -> plot=1, x_out=200.
